// File: rtl/conv_pkg.sv
// Shared defaults, FSM state encoding and operand lane indexing for the
// convolution multiply-accumulate engine.
package conv_pkg;

  localparam int DEF_LANES      = 3;
  localparam int DEF_BIT_LENGTH = 16;
  localparam int DEF_OUT_WIDTH  = 16;
  localparam int DEF_BEATS_W    = 8;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DRAIN,
    OUTPUT
  } convState_t;

  // Low bit index of a lane inside a flat operand bus.
  function automatic int laneLo(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/conv_lane_sum.sv
// Per-lane masked multipliers with registered products (E0) followed by a
// registered adder tree that folds all lanes into one accumulator-wide sum (E1).
module conv_lane_sum
  import conv_pkg::*;
#(
  parameter int LANES      = DEF_LANES,
  parameter int BIT_LENGTH = DEF_BIT_LENGTH,
  parameter int ACC_WIDTH  = 2*DEF_BIT_LENGTH+8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          beatValid,
  input  logic                          isSigned,
  input  logic [LANES-1:0]              laneMask,
  input  logic [LANES*BIT_LENGTH-1:0]   multiplier,
  input  logic [LANES*BIT_LENGTH-1:0]   multiplicand,
  output logic [ACC_WIDTH-1:0]          laneSum,
  output logic                          sumValid
);

  localparam int PW = 2*BIT_LENGTH;

  logic [PW-1:0]        prodComb [LANES];
  logic [PW-1:0]        prodReg  [LANES];
  logic                 prodValid;
  logic [ACC_WIDTH-1:0] treeSum;

  // Operands are extended to full product width first, so the low PW bits
  // of a plain multiply are correct for both signed and unsigned modes.
  for (genvar i = 0; i < LANES; i++) begin : gLane
    logic [BIT_LENGTH-1:0] opA, opB;
    logic [PW-1:0]         extA, extB;
    assign opA  = multiplier[laneLo(i, BIT_LENGTH) +: BIT_LENGTH];
    assign opB  = multiplicand[laneLo(i, BIT_LENGTH) +: BIT_LENGTH];
    assign extA = {{BIT_LENGTH{isSigned & opA[BIT_LENGTH-1]}}, opA};
    assign extB = {{BIT_LENGTH{isSigned & opB[BIT_LENGTH-1]}}, opB};
    assign prodComb[i] = laneMask[i] ? extA * extB : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prodValid <= 1'b0;
      for (int i = 0; i < LANES; i++) prodReg[i] <= '0;
    end else begin
      prodValid <= beatValid;
      if (beatValid) begin
        for (int i = 0; i < LANES; i++) prodReg[i] <= prodComb[i];
      end
    end
  end

  always_comb begin
    treeSum = '0;
    for (int i = 0; i < LANES; i++) begin
      treeSum = treeSum + {{(ACC_WIDTH-PW){isSigned & prodReg[i][PW-1]}}, prodReg[i]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      laneSum  <= '0;
      sumValid <= 1'b0;
    end else begin
      laneSum  <= treeSum;
      sumValid <= prodValid;
    end
  end

endmodule

// File: rtl/conv_mac_engine.sv
// Multi-lane convolution MAC: accumulates lane sums over a programmable beat
// count, then shifts, saturates and offers the result on a valid/ready port.
module conv_mac_engine
  import conv_pkg::*;
#(
  parameter int LANES      = DEF_LANES,
  parameter int BIT_LENGTH = DEF_BIT_LENGTH,
  parameter int ACC_WIDTH  = 2*BIT_LENGTH+8,
  parameter int OUT_WIDTH  = DEF_OUT_WIDTH,
  parameter int BEATS_W    = DEF_BEATS_W
) (
  input  logic                        Clk,
  input  logic                        Rst,
  input  logic                        start,
  input  logic [BEATS_W-1:0]          cfg_beats,
  input  logic [4:0]                  cfg_shift,
  input  logic                        cfg_signed,
  input  logic [LANES-1:0]            lane_en,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [LANES*BIT_LENGTH-1:0] multiplier_input,
  input  logic [LANES*BIT_LENGTH-1:0] multiplicand_input,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [OUT_WIDTH-1:0]        out_data,
  output logic                        out_sat,
  output logic                        busy,
  output logic                        done
);

  convState_t           state, stateNext;
  logic [BEATS_W-1:0]   beatsReg, beatCount;
  logic [4:0]           shiftReg;
  logic                 signedReg;
  logic [LANES-1:0]     laneMask;
  logic                 drainCnt;
  logic [ACC_WIDTH-1:0] acc, laneSum, shifted;
  logic                 sumValid;
  logic                 outValidReg, outSatReg;
  logic [OUT_WIDTH-1:0] outDataReg, clampData;
  logic                 clampSat;
  logic                 accept, lastBeat, handshake;

  assign in_ready  = (state == ACCUM);
  assign accept    = in_valid && in_ready;
  assign lastBeat  = accept && (beatCount == beatsReg - BEATS_W'(1));
  assign handshake = outValidReg && out_ready;
  assign out_valid = outValidReg;
  assign out_data  = outDataReg;
  assign out_sat   = outSatReg;
  assign busy      = (state != IDLE);
  assign done      = handshake;

  conv_lane_sum #(
    .LANES      (LANES),
    .BIT_LENGTH (BIT_LENGTH),
    .ACC_WIDTH  (ACC_WIDTH)
  ) uLaneSum (
    .clk          (Clk),
    .rst          (Rst),
    .beatValid    (accept),
    .isSigned     (signedReg),
    .laneMask     (laneMask),
    .multiplier   (multiplier_input),
    .multiplicand (multiplicand_input),
    .laneSum      (laneSum),
    .sumValid     (sumValid)
  );

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) state <= IDLE;
    else     state <= stateNext;
  end

  // DRAIN spans the lane-sum and accumulate edges; OUTPUT's first edge loads the result.
  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (start)     stateNext = ACCUM;
      ACCUM:   if (lastBeat)  stateNext = DRAIN;
      DRAIN:   if (drainCnt)  stateNext = OUTPUT;
      OUTPUT:  if (handshake) stateNext = IDLE;
      default:                stateNext = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      beatsReg  <= '0;
      beatCount <= '0;
      shiftReg  <= '0;
      signedReg <= 1'b0;
      laneMask  <= '0;
      drainCnt  <= 1'b0;
      acc       <= '0;
    end else begin
      if (state == IDLE && start) begin
        beatsReg  <= (cfg_beats == '0) ? BEATS_W'(1) : cfg_beats;
        shiftReg  <= cfg_shift;
        signedReg <= cfg_signed;
        laneMask  <= lane_en;
        beatCount <= '0;
        acc       <= '0;
      end else begin
        if (accept)   beatCount <= beatCount + BEATS_W'(1);
        if (sumValid) acc <= acc + laneSum;
      end
      drainCnt <= (state == DRAIN) ? ~drainCnt : 1'b0;
    end
  end

  always_comb begin
    if (signedReg) shifted = ACC_WIDTH'($signed(acc) >>> shiftReg);
    else           shifted = acc >> shiftReg;
    clampData = shifted[OUT_WIDTH-1:0];
    clampSat  = 1'b0;
    if (signedReg) begin
      if (!(&shifted[ACC_WIDTH-1:OUT_WIDTH-1]) && (|shifted[ACC_WIDTH-1:OUT_WIDTH-1])) begin
        clampSat  = 1'b1;
        clampData = shifted[ACC_WIDTH-1] ? {1'b1, {(OUT_WIDTH-1){1'b0}}}
                                         : {1'b0, {(OUT_WIDTH-1){1'b1}}};
      end
    end else if (|shifted[ACC_WIDTH-1:OUT_WIDTH]) begin
      clampSat  = 1'b1;
      clampData = '1;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      outValidReg <= 1'b0;
      outDataReg  <= '0;
      outSatReg   <= 1'b0;
    end else if (state == OUTPUT && !outValidReg) begin
      outValidReg <= 1'b1;
      outDataReg  <= clampData;
      outSatReg   <= clampSat;
    end else if (handshake) begin
      outValidReg <= 1'b0;
    end
  end

endmodule

// File: tb/tb_conv_mac_engine.sv
// Scoreboard bench for conv_mac_engine: jobs push hand-computed results into a
// queue and a negedge monitor pops and compares on every output handshake.
module tb_conv_mac_engine;

  localparam int LANES      = 3;
  localparam int BIT_LENGTH = 16;
  localparam int OUT_WIDTH  = 16;
  localparam int BEATS_W    = 8;

  typedef struct {
    logic [OUT_WIDTH-1:0] data;
    logic                 sat;
  } expResult_t;

  logic                        Clk = 1'b0;
  logic                        Rst = 1'b1;
  logic                        start = 1'b0;
  logic [BEATS_W-1:0]          cfg_beats = '0;
  logic [4:0]                  cfg_shift = '0;
  logic                        cfg_signed = 1'b0;
  logic [LANES-1:0]            lane_en = '0;
  logic                        in_valid = 1'b0;
  logic                        in_ready;
  logic [LANES*BIT_LENGTH-1:0] multiplier_input = '0;
  logic [LANES*BIT_LENGTH-1:0] multiplicand_input = '0;
  logic                        out_valid;
  logic                        out_ready = 1'b1;
  logic [OUT_WIDTH-1:0]        out_data;
  logic                        out_sat;
  logic                        busy;
  logic                        done;

  int         compared = 0;
  int         mismatched = 0;
  expResult_t expQ[$];

  conv_mac_engine #(
    .LANES      (LANES),
    .BIT_LENGTH (BIT_LENGTH),
    .OUT_WIDTH  (OUT_WIDTH),
    .BEATS_W    (BEATS_W)
  ) dut (
    .Clk                (Clk),
    .Rst                (Rst),
    .start              (start),
    .cfg_beats          (cfg_beats),
    .cfg_shift          (cfg_shift),
    .cfg_signed         (cfg_signed),
    .lane_en            (lane_en),
    .in_valid           (in_valid),
    .in_ready           (in_ready),
    .multiplier_input   (multiplier_input),
    .multiplicand_input (multiplicand_input),
    .out_valid          (out_valid),
    .out_ready          (out_ready),
    .out_data           (out_data),
    .out_sat            (out_sat),
    .busy               (busy),
    .done               (done)
  );

  always #5 Clk = ~Clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Monitor: every output handshake must match the oldest queued expectation.
  initial begin
    expResult_t e;
    forever begin
      @(negedge Clk);
      if (!Rst && out_valid && out_ready) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpectedResult", 64'(out_data), 64'hDEAD_0000);
        end else begin
          e = expQ.pop_front();
          checkOutput("resultData", 64'(out_data), 64'(e.data));
          checkOutput("resultSat", 64'(out_sat), 64'(e.sat));
          checkOutput("donePulse", 64'(done), 64'd1);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // One complete job; config is scrambled right after start to prove it was latched.
  task automatic applyStimulus(input logic sgn, input int beats, input int shift,
                               input logic [LANES-1:0] en,
                               input logic [LANES*BIT_LENGTH-1:0] a,
                               input logic [LANES*BIT_LENGTH-1:0] b,
                               input bit toggle, input int hold,
                               input logic [OUT_WIDTH-1:0] expData, input logic expSat);
    expResult_t e;
    int effBeats, accepted, cycles, n, m;
    effBeats = (beats == 0) ? 1 : beats;
    e.data = expData;
    e.sat  = expSat;
    expQ.push_back(e);
    out_ready = (hold == 0);

    @(posedge Clk); #1;
    cfg_signed = sgn;
    cfg_beats  = beats[BEATS_W-1:0];
    cfg_shift  = shift[4:0];
    lane_en    = en;
    multiplier_input   = a;
    multiplicand_input = b;
    in_valid = 1'b1;
    start    = 1'b1;
    @(posedge Clk); #1;
    start      = 1'b0;
    cfg_signed = ~sgn;
    cfg_beats  = 8'd200;
    cfg_shift  = 5'd7;
    lane_en    = ~en;

    accepted = 0;
    cycles   = 0;
    while (accepted < effBeats && cycles < 200) begin
      in_valid = toggle ? (cycles % 2 == 0) : 1'b1;
      @(negedge Clk);
      if (in_valid && in_ready) accepted++;
      @(posedge Clk); #1;
      cycles++;
    end
    in_valid = 1'b0;
    checkOutput("beatsAccepted", 64'(accepted), 64'(effBeats));
    checkOutput("inReadyDrop", 64'(in_ready), 64'd0);

    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge Clk);
      n++;
    end
    checkOutput("outLatency", 64'(n), 64'd4);

    for (int k = 0; k < hold; k++) begin
      @(posedge Clk); #1;
      start     = (k == 2);
      cfg_beats = 8'd1;
      @(negedge Clk);
      checkOutput("holdValid", 64'(out_valid), 64'd1);
      checkOutput("holdData", 64'(out_data), 64'(expData));
      checkOutput("holdBusy", 64'(busy), 64'd1);
    end
    if (hold > 0) begin
      @(posedge Clk); #1;
      start     = 1'b0;
      out_ready = 1'b1;
    end

    m = 0;
    while (busy && m < 20) begin
      @(posedge Clk); #1;
      m++;
    end
    checkOutput("returnIdle", 64'(busy), 64'd0);
    checkOutput("doneCleared", 64'(done), 64'd0);
    checkOutput("validCleared", 64'(out_valid), 64'd0);
    if (hold > 0) begin
      @(posedge Clk); #1;
      checkOutput("startIgnored", 64'(busy), 64'd0);
    end
  endtask

  initial begin
    repeat (2) @(posedge Clk);
    #1 Rst = 1'b0;
    @(negedge Clk);
    checkOutput("rstInReady", 64'(in_ready), 64'd0);
    checkOutput("rstOutValid", 64'(out_valid), 64'd0);
    checkOutput("rstOutData", 64'(out_data), 64'd0);
    checkOutput("rstOutSat", 64'(out_sat), 64'd0);
    checkOutput("rstBusy", 64'(busy), 64'd0);
    checkOutput("rstDone", 64'(done), 64'd0);

    // Abort a 9-beat job after 4 beats with an asynchronous reset.
    @(posedge Clk); #1;
    cfg_signed = 1'b0;
    cfg_beats  = 8'd9;
    cfg_shift  = 5'd0;
    lane_en    = 3'b111;
    multiplier_input   = {16'd100, 16'd100, 16'd100};
    multiplicand_input = {16'd100, 16'd100, 16'd100};
    start = 1'b1;
    @(posedge Clk); #1;
    start    = 1'b0;
    in_valid = 1'b1;
    repeat (4) @(posedge Clk);
    #1 in_valid = 1'b0;
    checkOutput("preAbortBusy", 64'(busy), 64'd1);
    #2 Rst = 1'b1;
    #1;
    checkOutput("abortInReady", 64'(in_ready), 64'd0);
    checkOutput("abortOutValid", 64'(out_valid), 64'd0);
    checkOutput("abortOutData", 64'(out_data), 64'd0);
    checkOutput("abortOutSat", 64'(out_sat), 64'd0);
    checkOutput("abortBusy", 64'(busy), 64'd0);
    checkOutput("abortDone", 64'(done), 64'd0);
    @(posedge Clk); #1 Rst = 1'b0;

    // (2,3,4)x(5,6,7) = 10+18+28 = 56
    applyStimulus(1'b0, 1, 0, 3'b111, {16'd4, 16'd3, 16'd2}, {16'd7, 16'd6, 16'd5},
                  1'b0, 0, 16'd56, 1'b0);
    // 9 beats of 3 x (-1*2) = -54
    applyStimulus(1'b1, 9, 0, 3'b111, {3{16'hFFFF}}, {3{16'd2}},
                  1'b0, 0, 16'hFFCA, 1'b0);
    // 3 x 0xFFFE0001 overflows 16 bits unsigned
    applyStimulus(1'b0, 1, 0, 3'b111, {3{16'hFFFF}}, {3{16'hFFFF}},
                  1'b0, 0, 16'hFFFF, 1'b1);
    // 3 x (-32768*32767) clamps to the most negative value
    applyStimulus(1'b1, 1, 0, 3'b111, {3{16'h8000}}, {3{16'h7FFF}},
                  1'b0, 0, 16'h8000, 1'b1);
    // 3 x 32767^2 clamps to the most positive value
    applyStimulus(1'b1, 1, 0, 3'b111, {3{16'h7FFF}}, {3{16'h7FFF}},
                  1'b0, 0, 16'h7FFF, 1'b1);
    // 3 x 0xFFFE0001 = 0x2FFFA0003, >> 31 = 5
    applyStimulus(1'b0, 1, 31, 3'b111, {3{16'hFFFF}}, {3{16'hFFFF}},
                  1'b0, 0, 16'd5, 1'b0);
    // beats=0 acts as 1; -(100+200+300) >>> 4 = -38
    applyStimulus(1'b1, 0, 4, 3'b111, {16'd300, 16'd200, 16'd100}, {3{16'hFFFF}},
                  1'b0, 0, 16'hFFDA, 1'b0);
    // Backpressure for 5 cycles with a start pulse while the result waits
    applyStimulus(1'b0, 1, 0, 3'b111, {16'd4, 16'd3, 16'd2}, {16'd7, 16'd6, 16'd5},
                  1'b0, 5, 16'd56, 1'b0);
    // Only lane 1 enabled: 2 beats of 3*4 = 24, in_valid toggling
    applyStimulus(1'b0, 2, 0, 3'b010, {16'd9, 16'd3, 16'd9}, {16'd9, 16'd4, 16'd9},
                  1'b1, 0, 16'd24, 1'b0);

    repeat (3) @(posedge Clk);
    checkOutput("queueDrained", 64'(expQ.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
